// File: rtl/wide_alu_seq.sv
// wide_alu_seq: sequences one 2*HW-bit operation through an external HW-bit
// combinational ALU as two half-width passes on consecutive cycles, chaining
// the shift carry between passes and registering the assembled result/flags.
//
// Optional feature macro: WIDE_ALU_SEQ_ROTATE_EN (adds ROT input; shifts
// become 2*HW-bit rotates when ROT=1 is latched with START).
//
// Ports:
//   CLK, RST_N          clock (rising edge), async active-low reset
//   START               request, sampled only in IDLE
//   OP, OPA, OPB, SC_IN opcode, operands, first-pass shift-in
//   ROT                 rotate select (only with WIDE_ALU_SEQ_ROTATE_EN)
//   BUSY, DONE          busy during both passes, one-cycle completion pulse
//   RESULT, CARRY,
//   ZERO, PARITY        registered result and flags
//   ALU_A, ALU_B,
//   ALU_OP, ALU_SC_IN   drives to the ALU
//   ALU_OUT, ALU_SC_OUT,
//   ALU_BEVEN           returns from the ALU

package wide_alu_seq_pkg;
    localparam logic [2:0] kAND = 3'd0;
    localparam logic [2:0] kXOR = 3'd1;
    localparam logic [2:0] kLSH = 3'd2;
    localparam logic [2:0] kRSH = 3'd3;
endpackage

module wide_alu_seq
    import wide_alu_seq_pkg::*;
#(
    parameter int unsigned HW = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic [2:0]      OP,
    input  logic [2*HW-1:0] OPA,
    input  logic [2*HW-1:0] OPB,
    input  logic            SC_IN,
`ifdef WIDE_ALU_SEQ_ROTATE_EN
    input  logic            ROT,
`endif
    output logic            BUSY,
    output logic            DONE,
    output logic [2*HW-1:0] RESULT,
    output logic            CARRY,
    output logic            ZERO,
    output logic            PARITY,
    output logic [HW-1:0]   ALU_A,
    output logic [HW-1:0]   ALU_B,
    output logic [2:0]      ALU_OP,
    output logic            ALU_SC_IN,
    input  logic [HW-1:0]   ALU_OUT,
    input  logic            ALU_SC_OUT,
    input  logic            ALU_BEVEN
);

    localparam int unsigned W = 2 * HW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Operands latched at acceptance
    logic [2:0]    op_q;
    logic [W-1:0]  opa_q;
    logic [W-1:0]  opb_q;
    logic          sc_q;
`ifdef WIDE_ALU_SEQ_ROTATE_EN
    logic          rot_q;
`endif

    // First-pass captures, held until the second pass completes
    logic [HW-1:0] p1_out_q;
    logic          p1_sc_q;
    logic          p1_bev_q;
    logic          p1_zero_q;

    // Registered result and flags
    logic [W-1:0]  res_q;
    logic          carry_q;
    logic          zero_q;
    logic          parity_q;

    logic          accept;
    logic          is_shift;
    logic          is_rsh;
    logic          first_sin;
    logic [HW-1:0] a_lo, a_hi, b_lo, b_hi;
    logic          out_zero;

    assign accept   = (state_q == S_IDLE) && START;
    assign is_rsh   = (op_q == kRSH);
    assign is_shift = (op_q == kLSH) || is_rsh;
    assign a_lo     = opa_q[HW-1:0];
    assign a_hi     = opa_q[W-1:HW];
    assign b_lo     = opb_q[HW-1:0];
    assign b_hi     = opb_q[W-1:HW];
    assign out_zero = (ALU_OUT == '0);

    // Shift-in for the first pass; a rotate feeds back the bit that the
    // second pass will shift out at the far end of the word.
    always_comb begin
`ifdef WIDE_ALU_SEQ_ROTATE_EN
        first_sin = rot_q ? (is_rsh ? opa_q[0] : opa_q[W-1]) : sc_q;
`else
        first_sin = sc_q;
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        ALU_A     = '0;
        ALU_B     = '0;
        ALU_OP    = kAND;
        ALU_SC_IN = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_FIRST;
            end
            S_FIRST: begin
                BUSY      = 1'b1;
                state_d   = S_SECOND;
                ALU_OP    = op_q;
                ALU_A     = is_rsh ? a_hi : a_lo;
                ALU_B     = is_rsh ? b_hi : b_lo;
                ALU_SC_IN = is_shift & first_sin;
            end
            S_SECOND: begin
                BUSY      = 1'b1;
                state_d   = S_DONE;
                ALU_OP    = op_q;
                ALU_A     = is_rsh ? a_lo : a_hi;
                ALU_B     = is_rsh ? b_lo : b_hi;
                ALU_SC_IN = is_shift & p1_sc_q;
            end
            S_DONE: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q      <= kAND;
            opa_q     <= '0;
            opb_q     <= '0;
            sc_q      <= 1'b0;
`ifdef WIDE_ALU_SEQ_ROTATE_EN
            rot_q     <= 1'b0;
`endif
            p1_out_q  <= '0;
            p1_sc_q   <= 1'b0;
            p1_bev_q  <= 1'b0;
            p1_zero_q <= 1'b1;
            res_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b1;
            parity_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= OP;
                opa_q <= OPA;
                opb_q <= OPB;
                sc_q  <= SC_IN;
`ifdef WIDE_ALU_SEQ_ROTATE_EN
                rot_q <= ROT;
`endif
            end
            if (state_q == S_FIRST) begin
                p1_out_q  <= ALU_OUT;
                p1_sc_q   <= ALU_SC_OUT;
                p1_bev_q  <= ALU_BEVEN;
                p1_zero_q <= out_zero;
            end
            // First-pass half is staged so RESULT only changes entering DONE
            if (state_q == S_SECOND) begin
                res_q    <= is_rsh ? {p1_out_q, ALU_OUT} : {ALU_OUT, p1_out_q};
                carry_q  <= is_shift & ALU_SC_OUT;
                parity_q <= p1_bev_q ^ ALU_BEVEN;
                zero_q   <= p1_zero_q & out_zero;
            end
        end
    end

    assign RESULT = res_q;
    assign CARRY  = carry_q;
    assign ZERO   = zero_q;
    assign PARITY = parity_q;

endmodule

// File: doc/wide_alu_seq.md
Name: wide_alu_seq

Overview:
- Upstream operand sequencer for the 8-bit combinational ALU.
- Accepts one 16-bit operation (AND, XOR, LSH, RSH) and issues it to the ALU as two 8-bit passes on consecutive cycles.
- Chains shift carry between the halves, then assembles a registered 16-bit result with carry, zero and parity flags.
- Sits between the control/register-read stage and the ALU. It consumes the ALU outputs and feeds the result to writeback.

Parameters:
- HW, 8, half-word width; must equal the ALU data width. Operand/result width is 2*HW.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  request; sampled only in IDLE.
- OP  input  3  opcode, definitions-package codes (kAND, kXOR, kLSH, kRSH).
- OPA  input  2*HW  operand A.
- OPB  input  2*HW  operand B (ignored for shifts).
- SC_IN  input  1  shift-in bit for the first shift pass.
- BUSY  output  1  high in FIRST/SECOND.
- DONE  output  1  one-cycle completion pulse.
- RESULT  output  2*HW  registered result.
- CARRY  output  1  final shift-out bit.
- ZERO  output  1  RESULT == 0.
- PARITY  output  1  0 = even ones count in RESULT, 1 = odd.
- ALU_A, ALU_B  output  HW  ALU operands.
- ALU_OP  output  3  ALU opcode.
- ALU_SC_IN  output  1  ALU shift/carry in.
- ALU_OUT  input  HW  ALU result.
- ALU_SC_OUT  input  1  ALU shift/carry out.
- ALU_BEVEN  input  1  ALU parity of ALU_OUT (0 even, 1 odd).

Behaviour:
- States: IDLE -> FIRST -> SECOND -> DONE -> IDLE.
- IDLE -> FIRST on START=1: OP, OPA, OPB, SC_IN latched into internal registers at that edge. No other transitions are conditional.
- Pass order:
  - kAND, kXOR, kLSH: FIRST = low half, SECOND = high half.
  - kRSH: FIRST = high half, SECOND = low half.
- ALU_SC_IN:
  - Shifts: FIRST uses the latched SC_IN; SECOND uses the ALU_SC_OUT value captured at the end of FIRST.
  - AND/XOR: 0 in both passes.
- Capture at the end of each pass: ALU_OUT goes into its half of the result register; ALU_SC_OUT and ALU_BEVEN go into per-pass flag registers. ZERO is computed locally from ALU_OUT (the ALU ZERO output is not used).
- Final flags:
  - CARRY = SECOND-pass ALU_SC_OUT for shifts, 0 otherwise.
  - PARITY = BEVEN(FIRST) XOR BEVEN(SECOND).
  - ZERO = both halves zero.
- Any other OP code: ALU_OP is driven unchanged; the ALU default case yields 0. Sequencing is identical, RESULT = 0, CARRY = 0, ZERO = 1.
- Latency: START sampled at edge k; DONE=1 during cycle k+3 (DONE state) for exactly one cycle.
- RESULT, CARRY, ZERO and PARITY update at the edge entering DONE and hold until the next completion.
- BUSY is 1 in FIRST and SECOND, 0 in IDLE and DONE.
- START in FIRST, SECOND or DONE is ignored (not queued). Latched operands are immune to input changes after acceptance.
- In IDLE and DONE: ALU_A = ALU_B = 0, ALU_SC_IN = 0, ALU_OP = kAND.
- Reset (RST_N=0, any state, including mid-operation):
  - Immediately: state = IDLE; BUSY = 0, DONE = 0, RESULT = 0, CARRY = 0, ZERO = 1, PARITY = 0; ALU drives return to IDLE values.
  - No DONE pulse for the aborted operation after release.

Optional Feature:
- Macro WIDE_ALU_SEQ_ROTATE_EN.
- Defined:
  - Adds input port ROT (1 bit), latched with START.
  - For kLSH with ROT=1, the FIRST-pass shift-in is latched OPA[2*HW-1] instead of SC_IN.
  - For kRSH with ROT=1, the FIRST-pass shift-in is latched OPA[0].
  - This gives a 16-bit rotate; CARRY still equals the bit shifted out.
  - ROT has no effect on AND/XOR.
- Undefined: ROT port absent; shifts always use SC_IN.

Test Plan:
- AND, OPA=0xF0F0, OPB=0x0FF0, START at edge k -> DONE at cycle k+3, RESULT=0x00F0, CARRY=0, ZERO=0, PARITY=0; BUSY high cycles k+1..k+2.
- LSH, OPA=0x8081, SC_IN=1 -> ALU_SC_IN 1 then 1; RESULT=0x0103, CARRY=1, PARITY=1.
- RSH, OPA=0x0180, SC_IN=0 -> high pass first (ALU_A=0x01), low pass ALU_SC_IN=1; RESULT=0x00C0, CARRY=0, ZERO=0, PARITY=0.
- XOR, OPA=OPB=0x1234 -> RESULT=0x0000, ZERO=1, PARITY=0.
- START with AND 0xFFFF/0xFFFF, second START (XOR) pulsed during SECOND, RST_N low in cycle k+2 then released -> second START ignored; outputs at reset values immediately; no DONE afterwards; next clean START completes normally.
- (WIDE_ALU_SEQ_ROTATE_EN) LSH, ROT=1, OPA=0x8000 -> RESULT=0x0001, CARRY=1; RSH, ROT=1, OPA=0x0001 -> RESULT=0x8000, CARRY=1.
